// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of DIGIT-wide slices in a WIDTH-bit operand.
    function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
        return (digit == 0) ? 32'd0 : width / digit;
    endfunction

    // Slice counter width; one bit minimum so a single-slice build still has a counter.
    function automatic int unsigned calc_cnt_w(input int unsigned ndig);
        return (ndig <= 1) ? 32'd1 : 32'($clog2(ndig));
    endfunction

endpackage

// File: rtl/adder_slice.sv
// DIGIT-bit combinational ripple adder built from half-adder gate pairs;
// exposes the carry into the top bit for overflow detection.
module adder_slice #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0] = c_in;

    // Each full adder is two half adders plus an OR merging their carries.
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic p;
        logic g;
        logic t;
        xor u_ha0_s (p,      a[i], b[i]);
        and u_ha0_c (g,      a[i], b[i]);
        xor u_ha1_s (sum[i], p,    c[i]);
        and u_ha1_c (t,      p,    c[i]);
        or  u_cmerge (c[i+1], g,   t);
    end

    assign c_out    = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: processes DIGIT bits per clock, LSB slice first,
// and presents the registered result with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int unsigned CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH (WIDTH >= 2)");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] res_next;

    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a        (a_sh[DIGIT-1:0]),
        .b        (b_sh[DIGIT-1:0]),
        .c_in     (carry),
        .sum      (slice_sum),
        .c_out    (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    // New slice enters at the top; after NDIG shifts the first slice sits at bit 0.
    assign res_next = (res_sh >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract is a + ~b + 1; c_in has no effect in that mode.
                        a_sh   <= a;
                        b_sh   <= sub ? ~b : b;
                        carry  <= sub | c_in;
                        cnt    <= '0;
                        res_sh <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    carry  <= slice_cout;
                    res_sh <= res_next;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_next;
                        c_out <= slice_cout;
                        ovf   <= slice_cout ^ slice_cmsb;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder across several WIDTH/DIGIT builds,
// compared against a plain-arithmetic reference model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        c_in;
    logic [31:0] a;
    logic [31:0] b;

    always #5 clk = ~clk;

    // Instance index: 0 W8D1, 1 W16D4, 2 W4D1, 3 W4D2, 4 W4D4, 5 W32D8
    logic        busy_o [6];
    logic        done_o [6];
    logic        cout_o [6];
    logic        ovf_o  [6];
    logic [31:0] sum_o  [6];
    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic [3:0]  sum4a;
    logic [3:0]  sum4b;
    logic [3:0]  sum4c;
    logic [31:0] sum32;

    assign sum_o[0] = 32'(sum8);
    assign sum_o[1] = 32'(sum16);
    assign sum_o[2] = 32'(sum4a);
    assign sum_o[3] = 32'(sum4b);
    assign sum_o[4] = 32'(sum4c);
    assign sum_o[5] = sum32;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .c_in(c_in),
        .busy(busy_o[0]), .done(done_o[0]), .sum(sum8), .c_out(cout_o[0]), .ovf(ovf_o[0]));
    serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]), .c_in(c_in),
        .busy(busy_o[1]), .done(done_o[1]), .sum(sum16), .c_out(cout_o[1]), .ovf(ovf_o[1]));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[3:0]), .b(b[3:0]), .c_in(c_in),
        .busy(busy_o[2]), .done(done_o[2]), .sum(sum4a), .c_out(cout_o[2]), .ovf(ovf_o[2]));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[3:0]), .b(b[3:0]), .c_in(c_in),
        .busy(busy_o[3]), .done(done_o[3]), .sum(sum4b), .c_out(cout_o[3]), .ovf(ovf_o[3]));
    serial_adder #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[3:0]), .b(b[3:0]), .c_in(c_in),
        .busy(busy_o[4]), .done(done_o[4]), .sum(sum4c), .c_out(cout_o[4]), .ovf(ovf_o[4]));
    serial_adder #(.WIDTH(32), .DIGIT(8)) u_w32d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy_o[5]), .done(done_o[5]), .sum(sum32), .c_out(cout_o[5]), .ovf(ovf_o[5]));

    int checks = 0;
    int errors = 0;

    function automatic int unsigned ndig_of(input int i);
        case (i)
            0:       return 8;
            1:       return 4;
            2:       return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    // Reference: returns {ovf, c_out, sum} for a w-bit add or subtract.
    function automatic logic [33:0] ref_op(input int unsigned w, input logic [31:0] x,
                                           input logic [31:0] y, input logic ci, input logic s);
        logic [63:0] mask;
        logic [63:0] xx;
        logic [63:0] yy;
        logic [63:0] full;
        logic [31:0] r;
        logic        co;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        xx   = {32'd0, x} & mask;
        yy   = (s ? ~{32'd0, y} : {32'd0, y}) & mask;
        full = xx + yy + {63'd0, (s ? 1'b1 : ci)};
        r    = 32'(full & mask);
        co   = full[w];
        ov   = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
        return {ov, co, r};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        a = x; b = y; c_in = ci; sub = s; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        repeat (12) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({busy_o[i], done_o[i], cout_o[i], ovf_o[i], sum_o[i]} !== 36'd0) begin
                errors++;
                $display("FAIL reset idx=%0d got=%h exp=0", i,
                         {busy_o[i], done_o[i], cout_o[i], ovf_o[i], sum_o[i]});
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed_w8();
        logic [33:0] last_exp;
        last_exp = '0;
        for (int t = 0; t < 3; t++) begin
            logic [31:0] x;
            logic [31:0] y;
            logic        s;
            logic [33:0] exp;
            int          lat;
            case (t)
                0:       begin x = 32'hFF; y = 32'h01; s = 1'b0; end
                1:       begin x = 32'h7F; y = 32'h01; s = 1'b0; end
                default: begin x = 32'h05; y = 32'h07; s = 1'b1; end
            endcase
            exp = ref_op(8, x, y, 1'b0, s);
            pulse(x, y, 1'b0, s);
            lat = 0;
            for (int k = 1; k <= 12 && lat == 0; k++) begin
                tick();
                if (k == 1) begin
                    checks++;
                    if (busy_o[0] !== 1'b1) begin
                        errors++;
                        $display("FAIL w8_busy_run t=%0d got=%b exp=1", t, busy_o[0]);
                    end
                end
                if (k == 4 && t > 0) begin
                    checks++;
                    if (sum8 !== last_exp[7:0]) begin
                        errors++;
                        $display("FAIL w8_sum_hold t=%0d got=%h exp=%h", t, sum8, last_exp[7:0]);
                    end
                end
                if (done_o[0]) lat = k;
            end
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL w8_latency t=%0d got=%0d exp=8", t, lat);
            end
            checks++;
            if ({ovf_o[0], cout_o[0], sum8, busy_o[0]} !== {exp[33:32], exp[7:0], 1'b0}) begin
                errors++;
                $display("FAIL w8_result t=%0d got=%b%b_%h exp=%b%b_%h", t, ovf_o[0], cout_o[0],
                         sum8, exp[33], exp[32], exp[7:0]);
            end
            tick();
            checks++;
            if (done_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL w8_done_pulse t=%0d got=%b exp=0", t, done_o[0]);
            end
            last_exp = exp;
        end
    endtask

    task automatic test_directed_w16();
        logic [33:0] exp;
        int          lat;
        drain();
        exp = ref_op(16, 32'h1234, 32'h0FFF, 1'b1, 1'b0);
        pulse(32'h1234, 32'h0FFF, 1'b1, 1'b0);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            tick();
            if (done_o[1]) lat = k;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL w16_latency got=%0d exp=4", lat);
        end
        checks++;
        if ({ovf_o[1], cout_o[1], sum16} !== {exp[33:32], exp[15:0]}) begin
            errors++;
            $display("FAIL w16_result got=%b%b_%h exp=%b%b_%h", ovf_o[1], cout_o[1], sum16,
                     exp[33], exp[32], exp[15:0]);
        end
    endtask

    task automatic test_start_in_run();
        logic [33:0] exp;
        int          lat;
        drain();
        exp = ref_op(8, 32'h11, 32'h22, 1'b0, 1'b0);
        pulse(32'h11, 32'h22, 1'b0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            tick();
            if (k == 2) begin
                a = 32'h55; b = 32'h66; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_o[0]) lat = k;
        end
        start = 1'b0;
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL run_ignore_latency got=%0d exp=8", lat);
        end
        checks++;
        if ({ovf_o[0], cout_o[0], sum8} !== {exp[33:32], exp[7:0]}) begin
            errors++;
            $display("FAIL run_ignore_result got=%b%b_%h exp=%b%b_%h", ovf_o[0], cout_o[0], sum8,
                     exp[33], exp[32], exp[7:0]);
        end
        // Start raised during the DONE cycle must chain straight into the next run.
        exp = ref_op(8, 32'h40, 32'h0F, 1'b0, 1'b0);
        pulse(32'h40, 32'h0F, 1'b0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            tick();
            if (done_o[0]) lat = k;
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL b2b_latency got=%0d exp=8", lat);
        end
        checks++;
        if ({ovf_o[0], cout_o[0], sum8} !== {exp[33:32], exp[7:0]}) begin
            errors++;
            $display("FAIL b2b_result got=%b%b_%h exp=%b%b_%h", ovf_o[0], cout_o[0], sum8,
                     exp[33], exp[32], exp[7:0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [33:0] exp;
        int          lat;
        drain();
        pulse(32'h12, 32'h34, 1'b0, 1'b0);
        repeat (3) tick();
        checks++;
        if (busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before got=%b exp=1", busy_o[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o[0], done_o[0], cout_o[0], ovf_o[0], sum8} !== 12'd0) begin
            errors++;
            $display("FAIL midrst_async_clear got=%h exp=0",
                     {busy_o[0], done_o[0], cout_o[0], ovf_o[0], sum8});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (done_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_done k=%0d got=%b exp=0", k, done_o[0]);
            end
        end
        rst_n = 1'b1;
        tick();
        exp = ref_op(8, 32'h10, 32'h20, 1'b0, 1'b0);
        pulse(32'h10, 32'h20, 1'b0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            tick();
            if (done_o[0]) lat = k;
        end
        checks++;
        if (lat != 8 || {ovf_o[0], cout_o[0], sum8} !== {exp[33:32], exp[7:0]}) begin
            errors++;
            $display("FAIL post_reset_op lat=%0d exp_lat=8 got=%b%b_%h exp=%b%b_%h", lat,
                     ovf_o[0], cout_o[0], sum8, exp[33], exp[32], exp[7:0]);
        end
    endtask

    task automatic test_exhaustive_w4();
        drain();
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int m = 0; m < 4; m++) begin
                    logic [33:0] exp;
                    int          lat [6];
                    logic        ci;
                    logic        s;
                    ci = m[0];
                    s  = m[1];
                    for (int i = 0; i < 6; i++) lat[i] = 0;
                    pulse(32'(x), 32'(y), ci, s);
                    for (int k = 1; k <= 4; k++) begin
                        tick();
                        for (int i = 2; i <= 4; i++)
                            if (done_o[i] && lat[i] == 0) lat[i] = k;
                    end
                    exp = ref_op(4, 32'(x), 32'(y), ci, s);
                    for (int i = 2; i <= 4; i++) begin
                        checks++;
                        if (lat[i] != int'(ndig_of(i))) begin
                            errors++;
                            $display("FAIL w4_latency idx=%0d a=%0d b=%0d m=%0d got=%0d exp=%0d",
                                     i, x, y, m, lat[i], ndig_of(i));
                        end
                        checks++;
                        if ({ovf_o[i], cout_o[i], sum_o[i][3:0]} !== {exp[33:32], exp[3:0]}) begin
                            errors++;
                            $display("FAIL w4_result idx=%0d a=%0d b=%0d m=%0d got=%b%b_%h exp=%b%b_%h",
                                     i, x, y, m, ovf_o[i], cout_o[i], sum_o[i][3:0],
                                     exp[33], exp[32], exp[3:0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_random_w32();
        drain();
        for (int n = 0; n < 10000; n++) begin
            logic [31:0] x;
            logic [31:0] y;
            logic        ci;
            logic        s;
            logic [33:0] exp;
            int          lat;
            x   = $urandom;
            y   = $urandom;
            ci  = 1'($urandom_range(0, 1));
            s   = 1'($urandom_range(0, 1));
            exp = ref_op(32, x, y, ci, s);
            pulse(x, y, ci, s);
            lat = 0;
            for (int k = 1; k <= 8 && lat == 0; k++) begin
                tick();
                if (done_o[5]) lat = k;
            end
            checks++;
            if (lat != 4 || {ovf_o[5], cout_o[5], sum32} !== exp) begin
                errors++;
                $display("FAIL w32_random n=%0d a=%h b=%h ci=%b sub=%b lat=%0d got=%b%b_%h exp=%b%b_%h",
                         n, x, y, ci, s, lat, ovf_o[5], cout_o[5], sum32, exp[33], exp[32], exp[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed_w8();
        test_directed_w16();
        test_start_in_run();
        test_reset_mid_run();
        test_exhaustive_w4();
        test_random_w32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
